// File: rtl/mux_scan_controller_pkg.sv
// Shared types and defaults for the four-channel mux scan controller.
package mux_scan_controller_pkg;

   localparam int DWELL_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mux_scan_controller_if.sv
// Scan request/result bundle between the controller and its user/mux.
interface mux_scan_controller_if
   import mux_scan_controller_pkg::*;
#(
   parameter int DWELL_W = DWELL_W_DEF
);

   logic               start;
   logic [DWELL_W-1:0] dwell;
   logic               mux_in;
   logic               sel_hi;
   logic               sel_lo;
   logic [3:0]         sample;
   logic               busy;
   logic               done;

   modport master (
      output start, dwell, mux_in,
      input  sel_hi, sel_lo, sample, busy, done
   );

   modport slave (
      input  start, dwell, mux_in,
      output sel_hi, sel_lo, sample, busy, done
   );

endinterface

// File: rtl/mux_scan_controller_dwell_counter.sv
// Per-channel dwell counter; tc flags the last cycle of a dwell.
module dwell_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc = en && (cnt_q == limit - W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = tc ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_scan_controller.sv
// Steps a 4:1 mux through all channels, capturing each after its dwell.
module mux_scan_controller
   import mux_scan_controller_pkg::*;
#(
   parameter int DWELL_W = DWELL_W_DEF
) (
   input logic                  clk,
   input logic                  rst,
   mux_scan_controller_if.slave bus
);

   state_e             state_q, state_d;
   logic [1:0]         ch_q, ch_d;
   logic [DWELL_W-1:0] d_q, d_d;
   logic [3:0]         shadow_q, shadow_d;
   logic [3:0]         sample_q, sample_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               tc;

   dwell_counter #(.W(DWELL_W)) u_dwell_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (state_q == SCAN),
      .limit (d_q),
      .tc    (tc)
   );

   // ch is only non-zero in SCAN, so it doubles as the select value
   assign {bus.sel_hi, bus.sel_lo} = ch_q;
   assign bus.sample               = sample_q;
   assign bus.busy                 = busy_q;
   assign bus.done                 = done_q;

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      d_d      = d_q;
      shadow_d = shadow_q;
      sample_d = sample_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SCAN;
               ch_d    = 2'd0;
               busy_d  = 1'b1;
               d_d     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
            end
         end
         SCAN: begin
            if (tc) begin
               shadow_d[ch_q] = bus.mux_in;
               ch_d           = ch_q + 2'd1;
               if (ch_q == 2'd3) begin
                  state_d  = DONE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  sample_d = {bus.mux_in, shadow_q[2:0]};
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ch_q     <= 2'd0;
         d_q      <= DWELL_W'(1);
         shadow_q <= 4'd0;
         sample_q <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         d_q      <= d_d;
         shadow_q <= shadow_d;
         sample_q <= sample_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: doc/mux_scan_controller.md
MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

Interface
REQ-001 Parameter DWELL_W, default 4: width of the per-channel dwell count.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request one scan of all four channels; sampled only in IDLE.
REQ-005 dwell  input  DWELL_W  cycles each channel is held selected; latched at scan start.
REQ-006 mux_in  input  1  sampled data, driven by the downstream 4:1 multiplexer output.
REQ-007 sel_hi  output  1  select MSB; drives the multiplexer's upper select line.
REQ-008 sel_lo  output  1  select LSB; drives the multiplexer's lower select line.
REQ-009 sample  output  4  captured channel values; bit n holds channel n.
REQ-010 busy  output  1  high while a scan is in progress.
REQ-011 done  output  1  one-cycle pulse when a completed scan is committed to sample.

Function
REQ-012 The block SHALL implement FSM states IDLE, SCAN and DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL enter SCAN with ch=0 and cnt=0, and latch D = dwell, with dwell=0 latched as 1.
REQ-014 {sel_hi, sel_lo} SHALL equal ch in SCAN and 2'b00 in IDLE and DONE.
REQ-015 In SCAN, cnt SHALL increment every edge; at the edge where cnt==D-1, shadow[ch] SHALL take mux_in, cnt SHALL clear and ch SHALL increment.
REQ-016 At the capture edge for ch==3, the FSM SHALL enter DONE and ch SHALL wrap to 0.
REQ-017 On entry to DONE, sample SHALL take the full shadow value (including the ch3 bit captured at that edge); sample SHALL otherwise hold.
REQ-018 done SHALL be 1 only in DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-019 busy SHALL be 1 exactly in SCAN, so busy is high for 4*D cycles per scan.
REQ-020 start in SCAN or DONE SHALL be ignored, with no queuing.
REQ-021 start held high SHALL begin a new scan on the first IDLE edge after DONE.
REQ-022 Latency: done SHALL assert 4*D cycles after the start-accept edge.
REQ-023 Changes to dwell during a scan SHALL NOT affect that scan.
REQ-024 Each channel SHALL be captured on the last of its D dwell cycles, giving D-1 cycles of settling.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE with ch=0, cnt=0, D=1, shadow=0, sample=0, busy=0, done=0 and sel=00; this takes priority over all other inputs.
REQ-026 Reset mid-scan SHALL abort the scan with no done pulse and no sample update.

Structure
REQ-027 The state encodings (IDLE=0, SCAN=1, DONE=2) and the DWELL_W default SHALL reside in the shared lab package/include file.
REQ-028 The dwell counter with its terminal-count flag SHALL be the one sub-module, named dwell_counter; the FSM, ch register and shadow/sample registers SHALL stay in the top module.

Verification
REQ-029 Reset, then idle 5 cycles -> sample=0000, busy=0, done=0, sel=00 throughout.
REQ-030 mux inputs {in3..in0}=1010, dwell=3, start pulse -> sel steps 00,01,10,11 for 3 cycles each; busy high for 12 cycles; done pulses 12 cycles after accept; sample=1010.
REQ-031 dwell=0, inputs 0110 -> each channel held 1 cycle; done 4 cycles after accept; sample=0110.
REQ-032 start re-pulsed in cycle 5 of a dwell=2 scan and dwell changed to 7 mid-scan -> no restart; done 8 cycles after accept; next scan uses the new dwell.
REQ-033 rst asserted during channel 2 of a scan whose previous result was 1111 -> next edge sample=0000, busy=0, sel=00; no done pulse.
REQ-034 start held high continuously with dwell=1 -> back-to-back scans, done every 6 cycles (4 SCAN + DONE + IDLE).
